spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  Receive-side counterpart of the SPI master: deserialises the mosi/sclk/ss
//  stream back into DATA_W-bit words inside the system clk domain. Inputs are
//  synchronised and edge-detected (no sclk clocking). Completed words go to a
//  small first-word-fall-through FIFO with a valid/ready output. Used as the
//  loopback/peer endpoint for the master and as the RX front end of the SPI link.
// PARAMETERS
//  DATA_W       8  bits per frame word, MSB first
//  SYNC_STAGES  2  synchroniser flops on sclk/mosi/ss (>=2)
//  FIFO_DEPTH   4  RX FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1                         system clock, all logic on posedge
//  rst_n      in   1                         synchronous, active-low reset
//  sclk       in   1                         SPI clock from master (idle low)
//  mosi       in   1                         SPI data from master
//  ss         in   1                         slave select, active low
//  rx_data    out  DATA_W                    FIFO head word (valid when rx_valid)
//  rx_valid   out  1                         FIFO not empty
//  rx_ready   in   1                         consumer pops head when rx_valid&rx_ready
//  rx_level   out  $clog2(FIFO_DEPTH+1)      FIFO occupancy
//  busy       out  1                         1 while in SHIFT state
//  frame_err  out  1                         1-cycle pulse: ss released mid-word
//  overflow   out  1                         sticky: word dropped, FIFO full
//  ovf_clr    in   1                         clears overflow (takes priority over set)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk): FIFO emptied, sync flops <= idle (sclk 0,
//   ss 1, mosi 0); rx_valid/busy/frame_err/overflow 0, rx_level 0, rx_data 0,
//   shift reg and bit counter 0. Reset mid-frame discards the partial word.
//  Sync/edge: sclk_s, mosi_s, ss_s = SYNC_STAGES-flop outputs; sclk_d = sclk_s
//   delayed 1 clk. fall = sclk_d & ~sclk_s. Master launches mosi on sclk
//   rising, so mosi_s is sampled on fall. sclk high/low times >= 1 clk each.
//  FSM IDLE: busy=0; sclk edges ignored. ss_s==0 -> SHIFT, bit_cnt<=0, shreg<=0.
//  FSM SHIFT: busy=1. On fall: shreg <= {shreg[DATA_W-2:0], mosi_s},
//   bit_cnt++. On the DATA_W-th fall: word {shreg[DATA_W-2:0],mosi_s} pushed to
//   FIFO same edge, bit_cnt<=0, stay SHIFT (back-to-back words, ss held low).
//  ss_s==1 in SHIFT: bit_cnt==0 -> IDLE silently; bit_cnt!=0 -> partial
//   discarded, frame_err=1 for exactly one cycle, IDLE. If ss_s rises in the
//   same cycle as the DATA_W-th fall, the word is pushed and no frame_err.
//  Latency: rx_valid rises after SYNC_STAGES+1 clk edges, counting the first
//   edge that samples raw sclk low after the last bit (empty FIFO).
//  FIFO: FWFT; rx_data = head. Pop when rx_valid&rx_ready. Push when full:
//   accepted only if a pop occurs same cycle (level unchanged), else word
//   dropped and overflow<=1. Push+pop when empty: push only. Pointers wrap
//   modulo FIFO_DEPTH; rx_level in 0..FIFO_DEPTH. rx_ready with empty ignored.
//  overflow holds until ovf_clr=1; ovf_clr and drop same cycle -> overflow=0.
// TESTING
//  1 Reset: rst_n=0 2 cycles mid-frame -> all outputs 0, rx_level 0, no word.
//  2 Single frame 0xA5 (master timing, rx_ready=1) -> one word 0xA5, rx_valid
//    at SYNC_STAGES+1 edges after last fall, busy drops after ss release.
//  3 ss low, 4 words 0x01,0x80,0xFF,0x3C, rx_ready=0 -> rx_level=4, pops
//    return same order; 5th word -> dropped, overflow=1; ovf_clr -> 0.
//  4 ss raised after 5 bits -> frame_err one-cycle pulse, no push; next frame
//    0x5A received correctly.
//  5 FIFO full + push & pop same cycle -> level stays 4, order preserved.
//  6 sclk toggling with ss=1 -> no pushes, busy=0, bit_cnt unaffected.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: synchronises sclk/mosi/ss into clk, samples mosi on sclk
// falling edges, and queues completed words in a first-word-fall-through FIFO.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sclk,
    input  logic                             mosi,
    input  logic                             ss,
    output logic [DATA_W-1:0]                rx_data,
    output logic                             rx_valid,
    input  logic                             rx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  rx_level,
    output logic                             busy,
    output logic                             frame_err,
    output logic                             overflow,
    input  logic                             ovf_clr
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
    logic                   sclk_d_q;
    logic                   sclk_s, mosi_s, ss_s, fall;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shreg_q, shreg_d;
    logic [DATA_W-1:0]      word;
    logic                   push, last_bit;
    logic                   frame_err_q, frame_err_d;

    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wptr_q, rptr_q;
    logic [LVL_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   pop, full, wr, drop;

    // Synchronisers reset to the bus idle levels so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            sclk_d_q    <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            sclk_d_q    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign fall   = sclk_d_q & ~sclk_s;

    assign word     = {shreg_q[DATA_W-2:0], mosi_s};
    assign last_bit = fall && (bit_cnt_q == CNT_W'(DATA_W-1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ss_s) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                end
            end
            SHIFT: begin
                if (fall) begin
                    shreg_d   = word;
                    bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
                    push      = last_bit;
                end
                // A word completing on the same cycle ss rises is still good.
                if (ss_s) begin
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    frame_err_d = !last_bit && (fall || bit_cnt_q != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pop  = (count_q != '0) && rx_ready;
    assign full = (count_q == LVL_W'(FIFO_DEPTH));
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (wr && !pop)      count_d = count_q + 1'b1;
        else if (!wr && pop) count_d = count_q - 1'b1;
        overflow_d = overflow_q;
        if (ovf_clr)   overflow_d = 1'b0;
        else if (drop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr)  wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= word;
    end

    assign rx_valid  = (count_q != '0);
    assign rx_data   = rx_valid ? mem_q[rptr_q] : '0;
    assign rx_level  = count_q;
    assign busy      = (state_q == SHIFT);
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames with master timing and
// checks the FIFO, status flags and latency against hand-computed values.
module tb_spi_slave_rx;

    logic       clk, rst_n, sclk, mosi, ss, rx_ready, ovf_clr;
    logic [7:0] rx_data;
    logic       rx_valid, busy, frame_err, overflow;
    logic [2:0] rx_level;
    int         tests, failed;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_level(rx_level), .busy(busy), .frame_err(frame_err),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rising edge launches the bit; falling edge is left at the end.
    task automatic bit_high(input logic b);
        @(negedge clk);
        mosi = b;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            bit_high(w[i]);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk({tag, "_valid"}, rx_valid, 1);
        chk({tag, "_data"}, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        tests = 0; failed = 0;
        rst_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss = 1'b1;
        rx_ready = 1'b0; ovf_clr = 1'b0;
        wait_clks(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_level", rx_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", rx_data, 0);
        rst_n = 1'b1;
        wait_clks(2);

        // Reset mid-frame discards the partial word
        ss = 1'b0;
        wait_clks(4);
        send_bits(8'hE0, 3);
        rst_n = 1'b0;
        wait_clks(2);
        chk("midrst_busy", busy, 0);
        chk("midrst_level", rx_level, 0);
        chk("midrst_ferr", frame_err, 0);
        chk("midrst_ovf", overflow, 0);
        ss = 1'b1;
        rst_n = 1'b1;
        wait_clks(6);
        chk("midrst_after_level", rx_level, 0);

        // Single frame 0xA5 with latency check on the final bit
        ss = 1'b0;
        wait_clks(4);
        chk("a5_busy", busy, 1);
        rx_ready = 1'b1;
        send_bits(8'hA5, 7);
        bit_high(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("a5_lat2_valid", rx_valid, 0);
        @(negedge clk);
        chk("a5_lat3_valid", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
        @(negedge clk);
        chk("a5_popped", rx_valid, 0);
        rx_ready = 1'b0;
        ss = 1'b1;
        wait_clks(2);
        chk("a5_busy_held", busy, 1);
        wait_clks(2);
        chk("a5_busy_drop", busy, 0);
        chk("a5_no_ferr", frame_err, 0);

        // Four back-to-back words fill the FIFO; a fifth is dropped
        ss = 1'b0;
        wait_clks(4);
        send_bits(8'h01, 8);
        send_bits(8'h80, 8);
        send_bits(8'hFF, 8);
        send_bits(8'h3C, 8);
        chk("fill_level", rx_level, 4);
        chk("fill_ovf0", overflow, 0);
        send_bits(8'hEE, 8);
        chk("drop_level", rx_level, 4);
        chk("drop_ovf", overflow, 1);
        wait_clks(3);
        chk("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Push into a full FIFO on the same cycle as a pop
        send_bits(8'h77, 7);
        bit_high(1'b1);
        @(negedge clk);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("pushpop_level", rx_level, 4);
        chk("pushpop_ovf", overflow, 0);
        wait_clks(3);
        ss = 1'b1;
        wait_clks(5);
        pop_chk("pop0", 8'h80);
        pop_chk("pop1", 8'hFF);
        pop_chk("pop2", 8'h3C);
        pop_chk("pop3", 8'h77);
        chk("drain_valid", rx_valid, 0);
        chk("drain_data", rx_data, 0);

        // ss released after 5 bits
        ss = 1'b0;
        wait_clks(4);
        send_bits(8'hF8, 5);
        ss = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ferr_early", frame_err, 0);
        @(negedge clk);
        chk("ferr_pulse", frame_err, 1);
        chk("ferr_busy", busy, 0);
        @(negedge clk);
        chk("ferr_one_cycle", frame_err, 0);
        chk("ferr_no_push", rx_level, 0);
        ss = 1'b0;
        wait_clks(4);
        send_bits(8'h5A, 8);
        ss = 1'b1;
        wait_clks(5);
        chk("after_ferr_level", rx_level, 1);
        pop_chk("after_ferr", 8'h5A);

        // sclk activity while deselected must be ignored
        for (int i = 0; i < 10; i++) begin
            bit_high(i[0]);
            wait_clks(4);
            chk("desel_busy", busy, 0);
        end
        chk("desel_level", rx_level, 0);
        ss = 1'b0;
        wait_clks(4);
        send_bits(8'hC3, 8);
        ss = 1'b1;
        wait_clks(5);
        chk("desel_next_level", rx_level, 1);
        pop_chk("desel_next", 8'hC3);
        chk("final_ferr", frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
